// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state encodings shared by the ALU sequencer
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ADD/SUB/AND/OR with carry/borrow and zero flags
module alu_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   // carry doubles as borrow for SUB so one flag serves both arithmetic ops
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - two-requester round-robin ALU sequencer with held response
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_id,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             busy,
   output logic [7:0]       ops_done
);

   state_e           state;
   state_e           state_nxt;
   logic             last_gnt;
   logic             any_valid;
   logic             gnt_id;
   logic             grant;
   logic [1:0]       cap_op;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;
   logic             cap_id;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_zero;

   assign any_valid = req0_valid | req1_valid;
   // on a tie the requester that did not win last time gets the slot
   assign gnt_id    = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
   assign grant     = req0_ready | req1_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any_valid) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_HOLD;
         ST_HOLD: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = (state != ST_IDLE);
      rsp_valid  = (state == ST_HOLD);
      if (state == ST_IDLE && !rst && any_valid) begin
         req0_ready = ~gnt_id;
         req1_ready = gnt_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt   <= 1'b1;
         cap_op     <= '0;
         cap_a      <= '0;
         cap_b      <= '0;
         cap_id     <= 1'b0;
         rsp_result <= '0;
         rsp_id     <= 1'b0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         ops_done   <= '0;
      end else begin
         if (grant) begin
            cap_op   <= gnt_id ? req1_op : req0_op;
            cap_a    <= gnt_id ? req1_a  : req0_a;
            cap_b    <= gnt_id ? req1_b  : req0_b;
            cap_id   <= gnt_id;
            last_gnt <= gnt_id;
         end
         if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            rsp_id     <= cap_id;
         end
         if (state == ST_HOLD && rsp_ready) begin
            ops_done <= ops_done + 8'd1;
         end
      end
   end

   alu_core #(
      .WIDTH(WIDTH)
   ) u_alu (
      .op    (cap_op),
      .a     (cap_a),
      .b     (cap_b),
      .result(alu_result),
      .carry (alu_carry),
      .zero  (alu_zero)
   );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench with a behavioural arbitration/ALU model
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0] req0_op, req1_op;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, busy;
   logic [7:0] rsp_result, ops_done;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_id(rsp_id), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
      .busy(busy), .ops_done(ops_done)
   );

   typedef struct {
      logic       id;
      logic [7:0] result;
      logic       carry;
      logic       zero;
   } rsp_t;

   int         checks = 0;
   int         errors = 0;
   rsp_t       exp_q[$];
   int         grant_log[$];
   bit         m_last = 1'b1;
   bit         m_busy = 1'b0;
   logic [7:0] m_ops = 8'd0;
   int         cyc = 0;
   int         gnt_cyc = 0;
   int         acc_count = 0;
   logic [7:0] acc_res;
   logic       acc_id, acc_c, acc_z;
   logic [7:0] prev_ops = 8'd0;
   bit         wrapped = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic rsp_t ref_op(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      rsp_t t;
      int ai = int'(a);
      int bi = int'(b);
      int r = 0;
      t.id = id;
      t.carry = 1'b0;
      case (op)
         2'd0: begin r = ai + bi; t.carry = (r > 255); r = r % 256; end
         2'd1: begin t.carry = (ai < bi); r = (ai - bi + 256) % 256; end
         2'd2: r = ai & bi;
         default: r = ai | bi;
      endcase
      t.result = r[7:0];
      t.zero = (r == 0);
      return t;
   endfunction

   // monitor: model of arbitration, latency and the response queue
   always @(negedge clk) begin
      bit exp_g;
      bit exp_valid;
      cyc++;
      if (rst) begin
         chk("ready_in_reset", {req1_ready, req0_ready}, 0);
         exp_q.delete();
         m_last = 1'b1;
         m_busy = 1'b0;
         m_ops = 8'd0;
         prev_ops = 8'd0;
      end else begin
         chk("ops_done", ops_done, m_ops);
         chk("busy", busy, m_busy);
         if (prev_ops == 8'd255 && ops_done == 8'd0) wrapped = 1'b1;
         prev_ops = ops_done;
         exp_valid = m_busy && (cyc - gnt_cyc >= 2);
         chk("rsp_valid", rsp_valid, exp_valid);
         if (m_busy) begin
            chk("ready_while_busy", {req1_ready, req0_ready}, 0);
         end else if (req0_valid || req1_valid) begin
            exp_g = (req0_valid && req1_valid) ? !m_last : req1_valid;
            chk("grant", {req1_ready, req0_ready}, exp_g ? 2'b10 : 2'b01);
            if (req0_ready || req1_ready) grant_log.push_back(int'(req1_ready));
            exp_q.push_back(exp_g ? ref_op(1'b1, req1_op, req1_a, req1_b)
                                  : ref_op(1'b0, req0_op, req0_a, req0_b));
            m_last = exp_g;
            m_busy = 1'b1;
            gnt_cyc = cyc;
         end else begin
            chk("ready_no_valid", {req1_ready, req0_ready}, 0);
         end
         if (exp_valid && rsp_valid && exp_q.size() > 0) begin
            chk("rsp_id", rsp_id, exp_q[0].id);
            chk("rsp_result", rsp_result, exp_q[0].result);
            chk("rsp_carry", rsp_carry, exp_q[0].carry);
            chk("rsp_zero", rsp_zero, exp_q[0].zero);
            if (rsp_ready) begin
               void'(exp_q.pop_front());
               m_ops = m_ops + 8'd1;
               m_busy = 1'b0;
               acc_res = rsp_result;
               acc_id = rsp_id;
               acc_c = rsp_carry;
               acc_z = rsp_zero;
               acc_count++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit rdy);
      bit got = 1'b0;
      rsp_ready = rdy;
      if (r) begin
         req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; req0_valid = 1'b0;
      end else begin
         req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; req1_valid = 1'b0;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = r ? req1_ready : req0_ready;
      end
      chk("issue_grant", got, 1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n0);
      for (int i = 0; i < 20 && acc_count == n0; i++) tick();
      chk("rsp_seen", acc_count, n0 + 1);
   endtask

   task automatic wait_rsp_valid();
      for (int i = 0; i < 10 && !rsp_valid; i++) tick();
      chk("rsp_valid_seen", rsp_valid, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      int n0;
      int s;
      logic [10:0] snap;
      bit g0, g1;
      rst = 1'b1;
      rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_op = 2'd0; req0_a = 8'd0; req0_b = 8'd0;
      req1_valid = 1'b0; req1_op = 2'd0; req1_a = 8'd0; req1_b = 8'd0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_result", rsp_result, 0);
      chk("reset_rsp_id", rsp_id, 0);
      chk("reset_rsp_carry", rsp_carry, 0);
      chk("reset_rsp_zero", rsp_zero, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ops_done", ops_done, 0);
      tick();

      n0 = acc_count;
      issue(1'b0, 2'd0, 8'hF0, 8'h20, 1'b1);
      wait_rsp(n0);
      chk("add_result", acc_res, 8'h10);
      chk("add_carry", acc_c, 1);
      chk("add_zero", acc_z, 0);
      chk("add_id", acc_id, 0);
      chk("add_ops_done", ops_done, 1);

      n0 = acc_count;
      issue(1'b1, 2'd1, 8'h05, 8'h05, 1'b1);
      wait_rsp(n0);
      chk("sub_eq_result", acc_res, 8'h00);
      chk("sub_eq_zero", acc_z, 1);
      chk("sub_eq_carry", acc_c, 0);
      chk("sub_eq_id", acc_id, 1);
      n0 = acc_count;
      issue(1'b1, 2'd1, 8'h03, 8'h05, 1'b1);
      wait_rsp(n0);
      chk("sub_borrow_result", acc_res, 8'hFE);
      chk("sub_borrow_carry", acc_c, 1);

      // both requesters valid back to back; operands churn while waiting
      s = grant_log.size();
      rsp_ready = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (14) begin
         req0_op = 2'($urandom_range(0, 3)); req0_a = 8'($urandom); req0_b = 8'($urandom);
         req1_op = 2'($urandom_range(0, 3)); req1_a = 8'($urandom); req1_b = 8'($urandom);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) tick();
      for (int k = 0; k < 4; k++) begin
         chk("alternate_grant", (grant_log.size() > s + k) ? grant_log[s + k] : -1, k % 2);
      end

      n0 = acc_count;
      issue(1'b0, 2'd2, 8'hCC, 8'hAA, 1'b0);
      req1_valid = 1'b1;
      wait_rsp_valid();
      snap = {rsp_id, rsp_carry, rsp_zero, rsp_result};
      repeat (5) tick();
      chk("hold_stable", {rsp_id, rsp_carry, rsp_zero, rsp_result}, snap);
      chk("hold_busy", busy, 1);
      chk("hold_ready", {req1_ready, req0_ready}, 0);
      chk("hold_count", acc_count, n0);
      rsp_ready = 1'b1;
      req1_valid = 1'b0;
      repeat (4) tick();
      chk("hold_once", acc_count, n0 + 1);
      chk("hold_result", acc_res, 8'h88);

      n0 = acc_count;
      issue(1'b1, 2'd3, 8'h0F, 8'h30, 1'b0);
      wait_rsp_valid();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_hold_valid", rsp_valid, 0);
      chk("rst_hold_busy", busy, 0);
      chk("rst_hold_ops", ops_done, 0);
      tick();
      rsp_ready = 1'b1;
      repeat (5) tick();
      chk("rst_hold_no_rsp", acc_count, n0);

      issue(1'b0, 2'd0, 8'h11, 8'h22, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      repeat (5) tick();
      chk("rst_exec_no_rsp", acc_count, n0);
      chk("rst_exec_ops", ops_done, 0);

      // random traffic, long enough for ops_done to wrap
      n0 = acc_count;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         tick();
         if (!req0_valid || g0) begin
            req0_valid = ($urandom_range(0, 99) < 70);
            req0_op = 2'($urandom_range(0, 3)); req0_a = 8'($urandom); req0_b = 8'($urandom);
         end else if ($urandom_range(0, 3) == 0) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom_range(0, 3));
         end
         if (!req1_valid || g1) begin
            req1_valid = ($urandom_range(0, 99) < 70);
            req1_op = 2'($urandom_range(0, 3)); req1_a = 8'($urandom); req1_b = 8'($urandom);
         end else if ($urandom_range(0, 3) == 0) begin
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom_range(0, 3));
         end
         rsp_ready = ($urandom_range(0, 99) < 80);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) tick();
      chk("random_enough_ops", (acc_count - n0) >= 256, 1);
      chk("ops_wrap", wrapped, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
